// File: rtl/gnrc_stream_arb_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gnrc_pkg : shared helpers for the gnrc stream blocks                 |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
package gnrc_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gnrc_stream_arb_mux_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gnrc_stream_arb_mux_if : N-port stream inputs plus tagged output     |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
interface gnrc_stream_arb_mux_if #(
    parameter int  N     = 2,
    parameter type DTYPE = logic,
    parameter int  AW    = 1
);
    DTYPE [N-1:0]   data_i;
    logic [N-1:0]   valid_i;
    logic [N-1:0]   ready_o;
    DTYPE           data_o;
    logic [AW-1:0]  src_o;
    logic           valid_o;
    logic           ready_i;

    modport slave  (input  data_i, valid_i, ready_i,
                    output ready_o, data_o, src_o, valid_o);
    modport master (output data_i, valid_i, ready_i,
                    input  ready_o, data_o, src_o, valid_o);
endinterface
`default_nettype wire

// File: rtl/gnrc_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gnrc_rr_arbiter : combinational round-robin grant from a pointer     |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
module gnrc_rr_arbiter
    import gnrc_pkg::*;
#(
    parameter int N  = 2,
    parameter int AW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [AW-1:0] ptr,
    output logic [AW-1:0] gnt_idx,
    output logic          gnt_vld
);

    // Walk from the farthest offset down so the port nearest ptr wins last.
    always_comb begin
        int k;
        k       = 0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (req[k]) begin
                gnt_idx = AW'(k);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gnrc_stream_arb_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gnrc_stream_arb_mux : round-robin N:1 stream mux, registered output  |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
module gnrc_stream_arb_mux
    import gnrc_pkg::*;
#(
    parameter int  N     = 2,
    parameter type DTYPE = logic,
    parameter int  AW    = idx_width(N)
) (
    input  wire logic            clk_i,
    input  wire logic            rst_ni,
    gnrc_stream_arb_mux_if.slave bus
);

    if (N < 1) begin : g_n_check
        $error("gnrc_stream_arb_mux: N must be >= 1");
    end

    logic          ovld_q, ovld_d;
    DTYPE          odata_q, odata_d;
    logic [AW-1:0] osrc_q, osrc_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] g;
    logic          any;
    logic          ld;

    assign ld = ~ovld_q | bus.ready_i;

    gnrc_rr_arbiter #(.N(N), .AW(AW)) u_arb (
        .req     (bus.valid_i),
        .ptr     (ptr_q),
        .gnt_idx (g),
        .gnt_vld (any)
    );

    always_comb begin
        bus.ready_o = '0;
        if (rst_ni && ld && any) bus.ready_o[g] = 1'b1;
    end

    // Drain and reload share one cycle whenever the output is consumed.
    always_comb begin
        ovld_d  = ovld_q;
        odata_d = odata_q;
        osrc_d  = osrc_q;
        ptr_d   = ptr_q;
        if (ld) begin
            if (any) begin
                ovld_d  = 1'b1;
                odata_d = bus.data_i[g];
                osrc_d  = g;
                ptr_d   = (g == AW'(N - 1)) ? '0 : g + AW'(1);
            end else begin
                ovld_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovld_q  <= 1'b0;
            odata_q <= '0;
            osrc_q  <= '0;
            ptr_q   <= '0;
        end else begin
            ovld_q  <= ovld_d;
            odata_q <= odata_d;
            osrc_q  <= osrc_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.valid_o = ovld_q;
    assign bus.data_o  = odata_q;
    assign bus.src_o   = osrc_q;

endmodule
`default_nettype wire
